gate_apply_1q: RTL

GATE_APPLY_1Q -- requirements
Module: gate_apply_1q

---
 rtl/qsim_pkg.sv | 40 ++++
 rtl/cmplx_mac_sm.sv | 97 +++++++++
 rtl/gate_apply_1q.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/qsim_pkg.sv
// qsim_pkg -- shared definitions for the quantum-simulator datapath blocks.
//
// Contents:
//   DATA_W   width of one real or imaginary component (sign-magnitude)
//   FRAC_W   fractional bits of the Q2.30 format (1.0 = 1 << FRAC_W)
//   state_e  sequencing states of gate_apply_1q
//   G_*      1-qubit gate indices understood by the gate ROM
//   gate_index()  maps an operation code onto a legal ROM index
package qsim_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 30;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ROW0 = 3'd1,
        ROW1 = 3'd2,
        CALC = 3'd3,
        OUT  = 3'd4
    } state_e;

    localparam logic [3:0] G_ZERO   = 4'd0;
    localparam logic [3:0] G_SIGMA0 = 4'd1;
    localparam logic [3:0] G_X      = 4'd2;
    localparam logic [3:0] G_Y      = 4'd3;
    localparam logic [3:0] G_Z      = 4'd4;
    localparam logic [3:0] G_H      = 4'd5;
    localparam logic [3:0] G_S      = 4'd6;
    localparam logic [3:0] G_SD     = 4'd7;
    localparam logic [3:0] G_T      = 4'd8;
    localparam logic [3:0] G_TD     = 4'd9;
    localparam logic [3:0] G_SQRTX  = 4'd10;

    // Codes above the last defined gate select the all-zero matrix, so an
    // unknown operation yields a zero result instead of garbage.
    function automatic logic [3:0] gate_index(input logic [3:0] op);
        return (op > G_SQRTX) ? G_ZERO : op;
    endfunction

endpackage

// File: rtl/cmplx_mac_sm.sv
// cmplx_mac_sm -- two-term complex multiply-accumulate on sign-magnitude data.
//
// Computes res = coef_a * amp_a + coef_b * amp_b (complex) with:
//   sign-magnitude -> two's complement (negative zero reads as 0),
//   full-precision product sum, arithmetic shift right by FRAC_W (floor),
//   saturation to +/- (2^(DATA_W-1) - 1), and conversion back to
//   sign-magnitude (never produces negative zero).
//
// The product sum is registered when en=1; the shift/saturate/convert
// stage after that register is combinational, so res is valid the cycle
// after en.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears the sums)
//   en                capture the product sums of the current operands
//   coef_a, coef_b    matrix entries, {real, imag}, real in the MSBs
//   amp_a, amp_b      amplitudes, {real, imag}, real in the MSBs
//   res               result, {real, imag}, real in the MSBs
module cmplx_mac_sm #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [2*DATA_W-1:0]   coef_a,
    input  logic [2*DATA_W-1:0]   coef_b,
    input  logic [2*DATA_W-1:0]   amp_a,
    input  logic [2*DATA_W-1:0]   amp_b,
    output logic [2*DATA_W-1:0]   res
);

    // Four products of magnitude < 2^(2*DATA_W-2) each: two guard bits above
    // the product width keep the signed sum exact.
    localparam int ACC_W = 2 * DATA_W + 2;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX;

    // Sign-magnitude component widened straight to the accumulator width.
    function automatic logic signed [ACC_W-1:0] sm_to_acc(input logic [DATA_W-1:0] v);
        logic [ACC_W-1:0] mag;
        mag = {{(ACC_W-DATA_W+1){1'b0}}, v[DATA_W-2:0]};
        return v[DATA_W-1] ? -$signed(mag) : $signed(mag);
    endfunction

    // Floor-shift, clamp and re-encode one accumulated component.
    function automatic logic [DATA_W-1:0] acc_to_sm(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        logic                    neg;
        logic [DATA_W-2:0]       mag;
        shifted = acc >>> FRAC_W;
        if (shifted > SAT_MAX) begin
            shifted = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            shifted = SAT_MIN;
        end
        neg = shifted[ACC_W-1];
        // Negative values are at least 1 in magnitude, so neg never pairs
        // with a zero magnitude.
        mag = (DATA_W-1)'(neg ? -shifted : shifted);
        return {neg, mag};
    endfunction

    logic signed [ACC_W-1:0] ar, ai, br, bi;
    logic signed [ACC_W-1:0] xr, xi, yr, yi;
    logic signed [ACC_W-1:0] sum_re, sum_im;
    logic signed [ACC_W-1:0] acc_re, acc_im;

    assign ar = sm_to_acc(coef_a[2*DATA_W-1:DATA_W]);
    assign ai = sm_to_acc(coef_a[DATA_W-1:0]);
    assign br = sm_to_acc(coef_b[2*DATA_W-1:DATA_W]);
    assign bi = sm_to_acc(coef_b[DATA_W-1:0]);
    assign xr = sm_to_acc(amp_a[2*DATA_W-1:DATA_W]);
    assign xi = sm_to_acc(amp_a[DATA_W-1:0]);
    assign yr = sm_to_acc(amp_b[2*DATA_W-1:DATA_W]);
    assign yi = sm_to_acc(amp_b[DATA_W-1:0]);

    // (a_r + j a_i)(x_r + j x_i) = (a_r x_r - a_i x_i) + j(a_r x_i + a_i x_r)
    assign sum_re = ar * xr - ai * xi + br * yr - bi * yi;
    assign sum_im = ar * xi + ai * xr + br * yi + bi * yr;

    // The register splits the multiplier tree from the saturation logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (en) begin
            acc_re <= sum_re;
            acc_im <= sum_im;
        end
    end

    assign res = {acc_to_sm(acc_re), acc_to_sm(acc_im)};

endmodule

// File: rtl/gate_apply_1q.sv
// gate_apply_1q -- applies a 2x2 complex gate matrix to a pair of amplitudes.
//
//   res0 = D0*amp0 + D1*amp1
//   res1 = D2*amp0 + D3*amp1
//
// The matrix comes from an external combinational ROM addressed by gate_sel
// and row_sel; row 0 returns {D0, D1}, row 1 returns {D2, D3}.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in OUT, and res0,
// res1 hold stable while out_valid=1 and out_ready=0.
//
// Sequence: IDLE -(accept)-> ROW0 -> ROW1 -> CALC (2 cycles) -> OUT -> IDLE.
// A request accepted at edge k shows out_valid=1 after edge k+4. CALC's first
// cycle loads the MAC product sums, its second registers res0/res1.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid, in_ready    request handshake
//   op_gate               gate index 0..10 (11..15 act as the zero gate)
//   amp0, amp1            input amplitudes {real, imag}, sign-magnitude Q2.30
//   gate_sel, row_sel     ROM address
//   gate_row              ROM data {Dar, Dai, Dbr, Dbi}
//   out_valid, out_ready  result handshake
//   res0, res1            result amplitudes {real, imag}
//   state_dbg             current FSM state
module gate_apply_1q
    import qsim_pkg::*;
#(
    parameter int DATA_W = qsim_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op_gate,
    input  logic [2*DATA_W-1:0]   amp0,
    input  logic [2*DATA_W-1:0]   amp1,
    output logic [3:0]            gate_sel,
    output logic                  row_sel,
    input  logic [4*DATA_W-1:0]   gate_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   res0,
    output logic [2*DATA_W-1:0]   res1,
    output state_e                state_dbg
);

    state_e                state;
    logic                  calc_phase;
    logic [2*DATA_W-1:0]   amp0_q, amp1_q;
    logic [2*DATA_W-1:0]   d0, d1, d2, d3;
    logic [2*DATA_W-1:0]   mac0, mac1;
    logic                  mac_en;

    assign state_dbg = state;
    assign mac_en    = (state == CALC) && !calc_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            calc_phase <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            gate_sel   <= G_ZERO;
            row_sel    <= 1'b0;
            res0       <= '0;
            res1       <= '0;
            amp0_q     <= '0;
            amp1_q     <= '0;
            d0         <= '0;
            d1         <= '0;
            d2         <= '0;
            d3         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        amp0_q   <= amp0;
                        amp1_q   <= amp1;
                        gate_sel <= gate_index(op_gate);
                        in_ready <= 1'b0;
                        row_sel  <= 1'b0;
                        state    <= ROW0;
                    end
                end
                ROW0: begin
                    d0      <= gate_row[4*DATA_W-1:2*DATA_W];
                    d1      <= gate_row[2*DATA_W-1:0];
                    row_sel <= 1'b1;
                    state   <= ROW1;
                end
                ROW1: begin
                    d2         <= gate_row[4*DATA_W-1:2*DATA_W];
                    d3         <= gate_row[2*DATA_W-1:0];
                    row_sel    <= 1'b0;
                    calc_phase <= 1'b0;
                    state      <= CALC;
                end
                CALC: begin
                    if (!calc_phase) begin
                        calc_phase <= 1'b1;
                    end else begin
                        calc_phase <= 1'b0;
                        res0       <= mac0;
                        res1       <= mac1;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        gate_sel  <= G_ZERO;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    gate_sel  <= G_ZERO;
                    row_sel   <= 1'b0;
                end
            endcase
        end
    end

    cmplx_mac_sm #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mac0 (
        .clk    (clk),
        .rst    (rst),
        .en     (mac_en),
        .coef_a (d0),
        .coef_b (d1),
        .amp_a  (amp0_q),
        .amp_b  (amp1_q),
        .res    (mac0)
    );

    cmplx_mac_sm #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mac1 (
        .clk    (clk),
        .rst    (rst),
        .en     (mac_en),
        .coef_a (d2),
        .coef_b (d3),
        .amp_a  (amp0_q),
        .amp_b  (amp1_q),
        .res    (mac1)
    );

endmodule
